pong_match_ctrl: RTL and testbench

//   Match sequencer for the ping-pong game. Runs on the game tick clock beside the ball/paddle motion logic.

---
 rtl/pong_pkg.sv | 24 ++
 rtl/pong_match_ctrl_if.sv | 30 +++
 rtl/pong_tick_timer.sv | 33 +++
 rtl/pong_match_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer.
package pong_pkg;

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned SPEED_W = 4;

    localparam logic [SPEED_W-1:0] BASE_SPEED = 4'd4;
    localparam logic [SPEED_W-1:0] MAX_SPEED  = 4'd8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } match_state_t;

    // Increment that sticks at lim.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s,
                                                     input logic [SCORE_W-1:0] lim);
        return (s >= lim) ? lim : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Game-side signals of the match sequencer; master = game environment, slave = controller.
interface pong_match_ctrl_if;
    import pong_pkg::*;

    logic               start_n;
    logic               miss_left;
    logic               miss_right;
    logic               paddle_hit;
    logic               ball_load;
    logic               ball_run;
    logic               serve_right;
    logic [SPEED_W-1:0] ball_speed;
    logic [SCORE_W-1:0] score_one;
    logic [SCORE_W-1:0] score_two;
    logic               game_over;
    logic [2:0]         state_o;

    modport master (
        output start_n, miss_left, miss_right, paddle_hit,
        input  ball_load, ball_run, serve_right, ball_speed,
        input  score_one, score_two, game_over, state_o
    );

    modport slave (
        input  start_n, miss_left, miss_right, paddle_hit,
        output ball_load, ball_run, serve_right, ball_speed,
        output score_one, score_two, game_over, state_o
    );

endinterface

// File: rtl/pong_tick_timer.sv
// Loadable down-counter that parks at zero; tc_o is high while the count is zero.
module pong_tick_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/point/over FSM, scoring and start edge detection.
// Optional ball speed-up on paddle hits is enabled with the SPEEDUP_EN macro.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = 9,
    parameter int unsigned SERVE_TICKS = 40,
    parameter int unsigned POINT_TICKS = 20,
    parameter int unsigned HITS_PER_UP = 4
) (
    input logic              t_clk,
    input logic              reset_n,
    pong_match_ctrl_if.slave bus
);

    localparam int unsigned TickMax = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int unsigned TimerW  = $clog2(TickMax) + 1;
    localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);

    match_state_t       state_q, state_d;
    logic [SCORE_W-1:0] score_one_q, score_one_d;
    logic [SCORE_W-1:0] score_two_q, score_two_d;
    logic               serve_right_q, serve_right_d;
    logic               ball_load_q, ball_load_d;
    logic               ball_run_q, game_over_q;
    logic               start_prev_q;
    logic               start_fall;
    logic               tmr_load, tmr_tc;
    logic [TimerW-1:0]  tmr_val;

    // Button must go high-to-low while idle; a press held across OVER->IDLE is ignored.
    assign start_fall = start_prev_q & ~bus.start_n;

    always_comb begin
        state_d       = state_q;
        score_one_d   = score_one_q;
        score_two_d   = score_two_q;
        serve_right_d = serve_right_q;
        ball_load_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_fall) begin
                    state_d     = SERVE;
                    ball_load_d = 1'b1;
                end
            end
            SERVE: begin
                if (tmr_tc) state_d = PLAY;
            end
            PLAY: begin
                if (bus.miss_left || bus.miss_right) begin
                    state_d = POINT;
                    if (bus.miss_left && !bus.miss_right) begin
                        score_two_d   = score_inc(score_two_q, WinScore);
                        serve_right_d = 1'b0;
                    end else if (bus.miss_right && !bus.miss_left) begin
                        score_one_d   = score_inc(score_one_q, WinScore);
                        serve_right_d = 1'b1;
                    end
                end
            end
            POINT: begin
                if (tmr_tc) begin
                    if (score_one_q == WinScore || score_two_q == WinScore) begin
                        state_d = OVER;
                    end else begin
                        state_d     = SERVE;
                        ball_load_d = 1'b1;
                    end
                end
            end
            OVER: begin
                if (!bus.start_n) begin
                    state_d     = IDLE;
                    score_one_d = '0;
                    score_two_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tmr_load = (state_d != state_q) && (state_d == SERVE || state_d == POINT);
    assign tmr_val  = (state_d == SERVE) ? TimerW'(SERVE_TICKS - 1) : TimerW'(POINT_TICKS - 1);

    pong_tick_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk_i      (t_clk),
        .rst_ni     (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    always_ff @(posedge t_clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            score_one_q   <= '0;
            score_two_q   <= '0;
            serve_right_q <= 1'b1;
            ball_load_q   <= 1'b1;
            ball_run_q    <= 1'b0;
            game_over_q   <= 1'b0;
            start_prev_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_one_q   <= score_one_d;
            score_two_q   <= score_two_d;
            serve_right_q <= serve_right_d;
            ball_load_q   <= ball_load_d;
            ball_run_q    <= (state_d == PLAY);
            game_over_q   <= (state_d == OVER);
            start_prev_q  <= bus.start_n;
        end
    end

`ifdef SPEEDUP_EN
    localparam int unsigned HitW = $clog2(HITS_PER_UP) + 1;

    logic [HitW-1:0]    hit_cnt_q, hit_cnt_d;
    logic [SPEED_W-1:0] speed_q, speed_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        speed_d   = speed_q;
        if (ball_load_d) begin
            hit_cnt_d = '0;
            speed_d   = BASE_SPEED;
        end else if (state_q == PLAY && bus.paddle_hit) begin
            if (hit_cnt_q == HitW'(HITS_PER_UP - 1)) begin
                hit_cnt_d = '0;
                if (speed_q < MAX_SPEED) speed_d = speed_q + SPEED_W'(1);
            end else begin
                hit_cnt_d = hit_cnt_q + HitW'(1);
            end
        end
    end

    always_ff @(posedge t_clk) begin
        if (!reset_n) begin
            hit_cnt_q <= '0;
            speed_q   <= BASE_SPEED;
        end else begin
            hit_cnt_q <= hit_cnt_d;
            speed_q   <= speed_d;
        end
    end

    assign bus.ball_speed = speed_q;
`else
    logic unused_paddle_hit;
    assign unused_paddle_hit = bus.paddle_hit & (HITS_PER_UP != 0) & (MAX_SPEED != 0);
    assign bus.ball_speed    = BASE_SPEED;
`endif

    assign bus.score_one   = score_one_q;
    assign bus.score_two   = score_two_q;
    assign bus.serve_right = serve_right_q;
    assign bus.ball_load   = ball_load_q;
    assign bus.ball_run    = ball_run_q;
    assign bus.game_over   = game_over_q;
    assign bus.state_o     = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: point outcomes go through a scoreboard queue.
module tb_pong_match_ctrl;

    localparam int unsigned StIdle = 0, StServe = 1, StPlay = 2, StPoint = 3, StOver = 4;
`ifdef SPEEDUP_EN
    localparam bit SpeedupOn = 1'b1;
`else
    localparam bit SpeedupOn = 1'b0;
`endif

    typedef struct {
        int unsigned s1;
        int unsigned s2;
        int unsigned sr;
    } exp_t;

    logic t_clk = 1'b0;
    logic reset_n;

    pong_match_ctrl_if dut_if ();

    pong_match_ctrl dut (
        .t_clk   (t_clk),
        .reset_n (reset_n),
        .bus     (dut_if.slave)
    );

    always #5 t_clk = ~t_clk;

    int unsigned assert_cnt = 0;
    int unsigned fail_cnt   = 0;
    exp_t        exp_q[$];
    int unsigned exp1 = 0, exp2 = 0, exp_sr = 1;
    logic [2:0]  prev_st = 3'd0;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: compare result of each point as the DUT enters POINT.
    always @(negedge t_clk) begin
        if (dut_if.state_o == 3'(StPoint) && prev_st != 3'(StPoint)) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_point", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("sb_score_one", dut_if.score_one, e.s1);
                check_eq("sb_score_two", dut_if.score_two, e.s2);
                check_eq("sb_serve_right", dut_if.serve_right, e.sr);
            end
        end
        prev_st <= dut_if.state_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge t_clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input int unsigned target, input int max_cyc);
        int n = 0;
        while (dut_if.state_o != 3'(target) && n < max_cyc) begin
            tick(1);
            n++;
        end
        check_eq(tag, dut_if.state_o, target);
    endtask

    task automatic play_point(input logic ml, input logic mr);
        exp_t e;
        if (ml && !mr) begin
            exp2   = (exp2 < 9) ? exp2 + 1 : 9;
            exp_sr = 0;
        end else if (mr && !ml) begin
            exp1   = (exp1 < 9) ? exp1 + 1 : 9;
            exp_sr = 1;
        end
        e.s1 = exp1; e.s2 = exp2; e.sr = exp_sr;
        exp_q.push_back(e);
        dut_if.miss_left  = ml;
        dut_if.miss_right = mr;
        tick(1);
        dut_if.miss_left  = 1'b0;
        dut_if.miss_right = 1'b0;
        check_eq("point_run_low", dut_if.ball_run, 0);
    endtask

    task automatic finish_point();
        wait_state("reload_serve", StServe, 50);
        check_eq("reload_pulse", dut_if.ball_load, 1);
        wait_state("reload_play", StPlay, 60);
    endtask

    task automatic pulse_hits(input int n);
        for (int i = 0; i < n; i++) begin
            dut_if.paddle_hit = 1'b1;
            tick(1);
            dut_if.paddle_hit = 1'b0;
            tick(1);
        end
    endtask

    initial begin
        int n;
        reset_n           = 1'b0;
        dut_if.start_n    = 1'b1;
        dut_if.miss_left  = 1'b0;
        dut_if.miss_right = 1'b0;
        dut_if.paddle_hit = 1'b0;

        // 1. reset
        tick(2);
        check_eq("rst_state", dut_if.state_o, StIdle);
        check_eq("rst_load", dut_if.ball_load, 1);
        check_eq("rst_run", dut_if.ball_run, 0);
        check_eq("rst_scores", {dut_if.score_one, dut_if.score_two}, 0);
        check_eq("rst_serve_right", dut_if.serve_right, 1);
        check_eq("rst_speed", dut_if.ball_speed, 4);
        check_eq("rst_over", dut_if.game_over, 0);
        reset_n = 1'b1;
        tick(1);
        check_eq("idle_load_clr", dut_if.ball_load, 0);

        // 2. serve
        dut_if.start_n = 1'b0;
        tick(1);
        dut_if.start_n = 1'b1;
        check_eq("serve_state", dut_if.state_o, StServe);
        check_eq("serve_load", dut_if.ball_load, 1);
        n = 1;
        while (!dut_if.ball_run && n < 200) begin
            tick(1);
            if (!dut_if.ball_run) n++;
        end
        check_eq("serve_ticks", n, 40);
        check_eq("play_state", dut_if.state_o, StPlay);

        // 3. held right-wall miss scores once
        begin
            exp_t e;
            exp1 = 1; exp_sr = 1;
            e.s1 = exp1; e.s2 = exp2; e.sr = exp_sr;
            exp_q.push_back(e);
        end
        dut_if.miss_right = 1'b1;
        tick(1);
        check_eq("miss_run_low", dut_if.ball_run, 0);
        check_eq("miss_point", dut_if.state_o, StPoint);
        tick(4);
        dut_if.miss_right = 1'b0;
        check_eq("held_miss_once", dut_if.score_one, 1);
        n = 5;
        while (dut_if.state_o == 3'(StPoint) && n < 200) begin
            tick(1);
            if (dut_if.state_o == 3'(StPoint)) n++;
        end
        check_eq("point_ticks", n, 20);
        check_eq("point_reload_state", dut_if.state_o, StServe);
        check_eq("point_reload_load", dut_if.ball_load, 1);
        check_eq("point_serve_right", dut_if.serve_right, 1);
        wait_state("p1_play", StPlay, 60);

        // 4. P2 to 9, match over
        for (int i = 0; i < 8; i++) begin
            play_point(1'b1, 1'b0);
            finish_point();
        end
        check_eq("p2_at_8", dut_if.score_two, 8);
        play_point(1'b1, 1'b0);
        wait_state("to_over", StOver, 50);
        check_eq("over_flag", dut_if.game_over, 1);
        check_eq("over_run", dut_if.ball_run, 0);
        dut_if.miss_left  = 1'b1;
        dut_if.miss_right = 1'b1;
        tick(3);
        dut_if.miss_left  = 1'b0;
        dut_if.miss_right = 1'b0;
        check_eq("over_frozen_one", dut_if.score_one, 1);
        check_eq("over_frozen_two", dut_if.score_two, 9);
        dut_if.start_n = 1'b0;
        tick(1);
        exp1 = 0; exp2 = 0;
        check_eq("over_to_idle", dut_if.state_o, StIdle);
        check_eq("idle_scores_clr", {dut_if.score_one, dut_if.score_two}, 0);
        check_eq("idle_over_clr", dut_if.game_over, 0);
        tick(3);
        check_eq("held_start_no_serve", dut_if.state_o, StIdle);
        dut_if.start_n = 1'b1;
        tick(1);

        // 5. simultaneous misses, then reset mid-serve
        dut_if.start_n = 1'b0;
        tick(1);
        dut_if.start_n = 1'b1;
        wait_state("t5_play", StPlay, 60);
        play_point(1'b1, 1'b1);
        check_eq("both_scores_kept", {dut_if.score_one, dut_if.score_two}, 0);
        wait_state("t5_serve", StServe, 50);
        tick(5);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        exp_sr  = 1;
        check_eq("mid_serve_rst_state", dut_if.state_o, StIdle);
        check_eq("mid_serve_rst_load", dut_if.ball_load, 1);
        check_eq("mid_serve_rst_sr", dut_if.serve_right, 1);
        tick(1);

        // 6. speed-up
        dut_if.start_n = 1'b0;
        tick(1);
        dut_if.start_n = 1'b1;
        wait_state("t6_play", StPlay, 60);
        pulse_hits(8);
        check_eq("speed_8_hits", dut_if.ball_speed, SpeedupOn ? 6 : 4);
        pulse_hits(12);
        check_eq("speed_sat", dut_if.ball_speed, SpeedupOn ? 8 : 4);
        play_point(1'b0, 1'b1);
        check_eq("speed_in_point", dut_if.ball_speed, SpeedupOn ? 8 : 4);
        wait_state("t6_serve", StServe, 50);
        check_eq("speed_reload", dut_if.ball_speed, 4);

        tick(2);
        check_eq("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
